// File: rtl/card_dealer.sv
// Card-supply stage: fetches ranks from the deck RAM, scores them and keeps player/dealer hands.
// Optional soft-ace scoring (ace = 11 with demotion) is enabled by defining SOFT_ACE_EN.
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int ADDR_W    = 6
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Clear,
    input  logic              i_Card2Player,
    input  logic              i_Card2Dealer,
    output logic              o_CardOK,
    output logic              o_DeckRd,
    output logic [ADDR_W-1:0] o_DeckAddr,
    input  logic [3:0]        i_DeckData,
    output logic [5:0]        o_HandP,
    output logic [5:0]        o_HandD,
    output logic              o_SoftP,
    output logic              o_SoftD,
    output logic [3:0]        o_LastCard,
    output logic              o_DeckWrap,
    output logic              o_BadCard
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ADD,
        ACK
    } state_e;

    state_e            state_q, state_d;
    logic              toPlayer_q, toPlayer_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [5:0]        handP_q, handP_d;
    logic [5:0]        handD_q, handD_d;
    logic [3:0]        last_q, last_d;
    logic              wrap_q, wrap_d;
    logic              bad_q, bad_d;

    logic [6:0]        cardVal;
    logic              cardBad;
    logic [5:0]        tgtHand;
    logic [6:0]        sum;
    logic [5:0]        newHand;

`ifdef SOFT_ACE_EN
    logic [2:0]        softP_q, softP_d;
    logic [2:0]        softD_q, softD_d;
    logic              cardAce;
    logic [2:0]        tgtSoft;
    logic [2:0]        newSoft;
`endif

    // Rank to point value; out-of-range ranks score nothing and are flagged.
    always_comb begin
        cardVal = '0;
        cardBad = 1'b0;
`ifdef SOFT_ACE_EN
        cardAce = 1'b0;
`endif
        if (i_DeckData == 4'd0 || i_DeckData >= 4'd14) begin
            cardBad = 1'b1;
        end else if (i_DeckData == 4'd1) begin
`ifdef SOFT_ACE_EN
            cardVal = 7'd11;
            cardAce = 1'b1;
`else
            cardVal = 7'd1;
`endif
        end else if (i_DeckData <= 4'd10) begin
            cardVal = {3'b000, i_DeckData};
        end else begin
            cardVal = 7'd10;
        end
    end

    // New total for the targeted hand; at most one ace is demoted per card.
    always_comb begin
        tgtHand = toPlayer_q ? handP_q : handD_q;
        sum     = {1'b0, tgtHand} + cardVal;
`ifdef SOFT_ACE_EN
        tgtSoft = toPlayer_q ? softP_q : softD_q;
        newSoft = tgtSoft + {2'b00, cardAce};
        if (sum > 7'd21 && newSoft != 3'd0) begin
            sum     = sum - 7'd10;
            newSoft = newSoft - 3'd1;
        end
`endif
        newHand = (sum > 7'd63) ? 6'd63 : sum[5:0];
    end

    always_comb begin
        state_d    = state_q;
        toPlayer_d = toPlayer_q;
        ptr_d      = ptr_q;
        handP_d    = handP_q;
        handD_d    = handD_q;
        last_d     = last_q;
        wrap_d     = wrap_q;
        bad_d      = bad_q;
`ifdef SOFT_ACE_EN
        softP_d    = softP_q;
        softD_d    = softD_q;
`endif
        if (i_Clear) begin
            // A card in flight is abandoned without advancing the pointer.
            state_d    = IDLE;
            toPlayer_d = 1'b0;
            ptr_d      = '0;
            handP_d    = '0;
            handD_d    = '0;
            last_d     = '0;
            wrap_d     = 1'b0;
            bad_d      = 1'b0;
`ifdef SOFT_ACE_EN
            softP_d    = '0;
            softD_d    = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Card2Player) begin
                        toPlayer_d = 1'b1;
                        state_d    = READ;
                    end else if (i_Card2Dealer) begin
                        toPlayer_d = 1'b0;
                        state_d    = READ;
                    end
                end
                READ: state_d = ADD;
                ADD: begin
                    if (toPlayer_q) begin
                        handP_d = newHand;
`ifdef SOFT_ACE_EN
                        softP_d = newSoft;
`endif
                    end else begin
                        handD_d = newHand;
`ifdef SOFT_ACE_EN
                        softD_d = newSoft;
`endif
                    end
                    last_d = i_DeckData;
                    bad_d  = bad_q | cardBad;
                    if (ptr_q == ADDR_W'(DECK_SIZE - 1)) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                    state_d = ACK;
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= IDLE;
            toPlayer_q <= 1'b0;
            ptr_q      <= '0;
            handP_q    <= '0;
            handD_q    <= '0;
            last_q     <= '0;
            wrap_q     <= 1'b0;
            bad_q      <= 1'b0;
`ifdef SOFT_ACE_EN
            softP_q    <= '0;
            softD_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            toPlayer_q <= toPlayer_d;
            ptr_q      <= ptr_d;
            handP_q    <= handP_d;
            handD_q    <= handD_d;
            last_q     <= last_d;
            wrap_q     <= wrap_d;
            bad_q      <= bad_d;
`ifdef SOFT_ACE_EN
            softP_q    <= softP_d;
            softD_q    <= softD_d;
`endif
        end
    end

    assign o_CardOK   = (state_q == ACK);
    assign o_DeckRd   = (state_q == READ);
    assign o_DeckAddr = ptr_q;
    assign o_HandP    = handP_q;
    assign o_HandD    = handD_q;
    assign o_LastCard = last_q;
    assign o_DeckWrap = wrap_q;
    assign o_BadCard  = bad_q;
`ifdef SOFT_ACE_EN
    assign o_SoftP    = (softP_q != 3'd0);
    assign o_SoftD    = (softD_q != 3'd0);
`else
    assign o_SoftP    = 1'b0;
    assign o_SoftD    = 1'b0;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a deck RAM model, a table of scored cards, and a
// scoreboard of expected hand state popped on every card-accepted pulse.
module tb_card_dealer;

    localparam int DECK_SIZE = 52;
    localparam int ADDR_W    = 6;
`ifdef SOFT_ACE_EN
    localparam int SA = 1;
`else
    localparam int SA = 0;
`endif

    logic              i_Clk = 1'b0;
    logic              i_Reset_n = 1'b0;
    logic              i_Clear = 1'b0;
    logic              i_Card2Player = 1'b0;
    logic              i_Card2Dealer = 1'b0;
    logic              o_CardOK;
    logic              o_DeckRd;
    logic [ADDR_W-1:0] o_DeckAddr;
    logic [3:0]        deckData = 4'd0;
    logic [5:0]        o_HandP;
    logic [5:0]        o_HandD;
    logic              o_SoftP;
    logic              o_SoftD;
    logic [3:0]        o_LastCard;
    logic              o_DeckWrap;
    logic              o_BadCard;

    logic [3:0]        deckMem [0:63];

    typedef struct {
        int p;
        int d;
        int sp;
        int sd;
        int last;
        int bad;
        int wrap;
    } exp_t;

    typedef struct {
        bit   clr;
        bit   toP;
        int   rank;
        exp_t e;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   ptrModel = 0;

    always #5 i_Clk = ~i_Clk;

    card_dealer #(.DECK_SIZE(DECK_SIZE), .ADDR_W(ADDR_W)) dut (
        .i_Clk         (i_Clk),
        .i_Reset_n     (i_Reset_n),
        .i_Clear       (i_Clear),
        .i_Card2Player (i_Card2Player),
        .i_Card2Dealer (i_Card2Dealer),
        .o_CardOK      (o_CardOK),
        .o_DeckRd      (o_DeckRd),
        .o_DeckAddr    (o_DeckAddr),
        .i_DeckData    (deckData),
        .o_HandP       (o_HandP),
        .o_HandD       (o_HandD),
        .o_SoftP       (o_SoftP),
        .o_SoftD       (o_SoftD),
        .o_LastCard    (o_LastCard),
        .o_DeckWrap    (o_DeckWrap),
        .o_BadCard     (o_BadCard)
    );

    // Synchronous deck RAM: data follows the cycle after the read strobe.
    always @(posedge i_Clk) begin
        if (o_DeckRd) deckData <= deckMem[o_DeckAddr];
    end

    function automatic exp_t mk(input int p, input int d, input int sp, input int sd,
                                input int last, input int bad, input int wrap);
        exp_t e;
        e.p = p; e.d = d; e.sp = sp; e.sd = sd; e.last = last; e.bad = bad; e.wrap = wrap;
        return e;
    endfunction

    task automatic addVec(input bit clr, input bit toP, input int rank, input int p, input int d,
                          input int sp, input int sd, input int bad);
        vec_t v;
        v.clr = clr;
        v.toP = toP;
        v.rank = rank;
        v.e = mk(p, d, sp, sd, rank, bad, 0);
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compareState(input string name, input exp_t e);
        checkOutput({name, " handP"}, int'(o_HandP), e.p);
        checkOutput({name, " handD"}, int'(o_HandD), e.d);
        checkOutput({name, " softP"}, int'(o_SoftP), e.sp);
        checkOutput({name, " softD"}, int'(o_SoftD), e.sd);
        checkOutput({name, " lastCard"}, int'(o_LastCard), e.last);
        checkOutput({name, " badCard"}, int'(o_BadCard), e.bad);
        checkOutput({name, " deckWrap"}, int'(o_DeckWrap), e.wrap);
    endtask

    // Waits for the next card-accepted pulse; the request must have been raised in IDLE.
    task automatic waitCardOk(input string name);
        bit   seen = 0;
        int   rd = 0;
        exp_t e;
        for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
            @(negedge i_Clk);
            if (o_DeckRd) begin
                rd++;
                checkOutput({name, " addr"}, int'(o_DeckAddr), ptrModel);
            end
            if (o_CardOK) begin
                seen = 1;
                checkOutput({name, " latency"}, cyc, 3);
                checkOutput({name, " reads"}, rd, 1);
                if (sbQ.size() == 0) begin
                    checkOutput({name, " unexpected cardok"}, 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    compareState(name, e);
                end
                ptrModel = (ptrModel == DECK_SIZE - 1) ? 0 : ptrModel + 1;
            end
        end
        if (!seen) begin
            checkOutput({name, " cardok timeout"}, 0, 1);
            if (sbQ.size() != 0) void'(sbQ.pop_front());
        end
    endtask

    task automatic applyStimulus(input bit toP, input int rank, input exp_t e, input string name);
        deckMem[ptrModel] = 4'(rank);
        sbQ.push_back(e);
        @(posedge i_Clk); #1;
        if (toP) i_Card2Player = 1'b1;
        else     i_Card2Dealer = 1'b1;
        waitCardOk(name);
        @(posedge i_Clk); #1;
        i_Card2Player = 1'b0;
        i_Card2Dealer = 1'b0;
    endtask

    task automatic applyClear();
        @(posedge i_Clk); #1;
        i_Clear = 1'b1;
        @(posedge i_Clk); #1;
        i_Clear = 1'b0;
        ptrModel = 0;
    endtask

    task automatic checkQuiet(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge i_Clk);
            if (o_CardOK || o_DeckRd) cnt++;
        end
        checkOutput(name, cnt, 0);
    endtask

    initial begin
        int pM;
        int dM;
        bit toP;

        for (int i = 0; i < 64; i++) deckMem[i] = 4'd0;

        // clr, toP, rank, handP, handD, softP, softD, bad
        addVec(1, 1, 1,  SA ? 11 : 1,  0, SA, 0, 0);
        addVec(0, 1, 13, SA ? 21 : 11, 0, SA, 0, 0);
        addVec(1, 1, 1,  SA ? 11 : 1,  0, SA, 0, 0);
        addVec(0, 1, 1,  SA ? 12 : 2,  0, SA, 0, 0);
        addVec(0, 1, 9,  SA ? 21 : 11, 0, SA, 0, 0);
        addVec(0, 1, 5,  16, 0, 0, 0, 0);
        addVec(1, 1, 7,  7, 0, 0, 0, 0);
        addVec(0, 0, 4,  7, 4, 0, 0, 0);
        addVec(0, 0, 12, 7, 14, 0, 0, 0);
        addVec(0, 1, 0,  7, 14, 0, 0, 1);
        addVec(0, 0, 15, 7, 14, 0, 0, 1);
        addVec(1, 0, 1,  0, SA ? 11 : 1,  0, SA, 0);
        addVec(0, 0, 10, 0, SA ? 21 : 11, 0, SA, 0);
        addVec(0, 0, 5,  0, 16, 0, 0, 0);

        #12;
        checkOutput("reset cardOK", int'(o_CardOK), 0);
        checkOutput("reset deckRd", int'(o_DeckRd), 0);
        checkOutput("reset deckAddr", int'(o_DeckAddr), 0);
        compareState("reset", mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge i_Clk); #1;
        i_Reset_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].clr) applyClear();
            applyStimulus(vecs[i].toP, vecs[i].rank, vecs[i].e, $sformatf("vec %0d", i));
        end

        // Both requests together: player first, dealer only after its own IDLE sample.
        applyClear();
        deckMem[0] = 4'd7;
        deckMem[1] = 4'd4;
        sbQ.push_back(mk(7, 0, 0, 0, 7, 0, 0));
        sbQ.push_back(mk(7, 4, 0, 0, 4, 0, 0));
        @(posedge i_Clk); #1;
        i_Card2Player = 1'b1;
        i_Card2Dealer = 1'b1;
        waitCardOk("both player");
        @(posedge i_Clk); #1;
        i_Card2Player = 1'b0;
        waitCardOk("both dealer");
        @(posedge i_Clk); #1;
        i_Card2Dealer = 1'b0;
        checkQuiet("both no extra card", 8);

        // Clear while the card is in ADD.
        applyClear();
        applyStimulus(1, 3, mk(3, 0, 0, 0, 3, 0, 0), "pre clear");
        deckMem[ptrModel] = 4'd9;
        @(posedge i_Clk); #1;
        i_Card2Player = 1'b1;
        @(posedge i_Clk);
        @(posedge i_Clk); #1;
        i_Clear = 1'b1;
        @(posedge i_Clk); #1;
        i_Clear = 1'b0;
        i_Card2Player = 1'b0;
        ptrModel = 0;
        checkQuiet("clear no cardok", 6);
        checkOutput("clear handP", int'(o_HandP), 0);
        checkOutput("clear lastCard", int'(o_LastCard), 0);
        applyStimulus(1, 6, mk(6, 0, 0, 0, 6, 0, 0), "post clear");

        // Asynchronous reset while the card is in READ.
        applyStimulus(0, 8, mk(6, 8, 0, 0, 8, 0, 0), "pre reset");
        deckMem[ptrModel] = 4'd9;
        @(posedge i_Clk); #1;
        i_Card2Player = 1'b1;
        @(posedge i_Clk); #1;
        i_Reset_n = 1'b0;
        #1;
        checkOutput("in reset cardOK", int'(o_CardOK), 0);
        checkOutput("in reset deckRd", int'(o_DeckRd), 0);
        checkOutput("in reset deckAddr", int'(o_DeckAddr), 0);
        checkOutput("in reset handP", int'(o_HandP), 0);
        checkOutput("in reset handD", int'(o_HandD), 0);
        i_Card2Player = 1'b0;
        #1;
        i_Reset_n = 1'b1;
        ptrModel = 0;
        checkQuiet("reset no cardok", 6);
        applyStimulus(0, 2, mk(0, 2, 0, 0, 2, 0, 0), "post reset");

        // 53 cards: wrap flag on the 52nd, 53rd read back at address 0.
        applyClear();
        pM = 0;
        dM = 0;
        for (int i = 0; i < DECK_SIZE + 1; i++) begin
            toP = (i % 2 == 0);
            if (toP) pM += 2;
            else     dM += 2;
            applyStimulus(toP, 2, mk(pM, dM, 0, 0, 2, 0, (i >= DECK_SIZE - 1) ? 1 : 0),
                          $sformatf("wrap %0d", i));
        end

        checkOutput("scoreboard empty", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Downstream card-supply stage for the blackjack controller. Serves the controller's level-held player/dealer card requests: fetches the next rank from the shuffled-deck RAM, converts it to a point value, accumulates player and dealer hands with soft-ace handling, and returns a one-cycle card-accepted pulse. Its hand totals are the controller's hand inputs, and its card-accepted pulse is the controller's card-accepted input.

## Interface
Parameters:
- DECK_SIZE, 52, cards per deck; pointer wraps after this many reads.
- ADDR_W, 6, deck address width; must satisfy 2**ADDR_W >= DECK_SIZE.

Ports:
- i_Clk  in  1  system clock; all state on rising edge.
- i_Reset_n  in  1  reset, asynchronous assert, active-low.
- i_Clear  in  1  synchronous new-game clear.
- i_Card2Player  in  1  level request: one card to player.
- i_Card2Dealer  in  1  level request: one card to dealer.
- o_CardOK  out  1  one-cycle pulse: requested card added.
- o_DeckRd  out  1  deck RAM read strobe.
- o_DeckAddr  out  ADDR_W  deck RAM address.
- i_DeckData  in  4  card rank, 1..13, valid the cycle after o_DeckRd.
- o_HandP  out  6  player hand total.
- o_HandD  out  6  dealer hand total.
- o_SoftP  out  1  player holds at least one ace counted as 11.
- o_SoftD  out  1  dealer holds at least one ace counted as 11.
- o_LastCard  out  4  rank of most recent card added.
- o_DeckWrap  out  1  sticky: deck pointer has wrapped.
- o_BadCard  out  1  sticky: rank 0 or 14..15 was read.

## Operation
- FSM states: IDLE, READ, ADD, ACK.
- IDLE:
  - Sample the requests.
  - If i_Card2Player is high, go to READ with target = player. Player has priority when both requests are high.
  - Otherwise, if i_Card2Dealer is high, go to READ with target = dealer.
  - Otherwise, stay in IDLE.
- READ: o_DeckRd=1 and o_DeckAddr=pointer; go to ADD.
- ADD:
  - Capture i_DeckData and update the target hand. Increment the pointer; at DECK_SIZE-1 it wraps to 0 and sets o_DeckWrap.
  - Go to ACK.
- ACK: o_CardOK=1 for one cycle. Requests are ignored in this state. Return to IDLE.
- Value mapping:
  - Rank 1 (ace) = 11 and increments the target's soft count.
  - Ranks 2..10 = face value.
  - Ranks 11..13 = 10.
  - Ranks 0 and 14..15 = 0 and set o_BadCard.
- Soft-ace rule, evaluated in a single ADD cycle: sum = hand + value. If sum > 21 and soft count > 0 (the count includes the new ace), then sum -= 10 and soft count decrements.
- Width rules:
  - Soft counts are 3 bits.
  - Arithmetic uses 7 bits internally; hands saturate at 63.
  - Under the controller's rules a hand never exceeds 31.
- i_Clear:
  - Valid in any state; zeroes hands, soft counts, pointer, o_LastCard, o_DeckWrap and o_BadCard; returns the FSM to IDLE.
  - An in-flight card is dropped: no o_CardOK, and the pointer is not advanced.
  - i_Clear has priority over every other action in the same cycle.
- Reset (i_Reset_n=0): same clearing as i_Clear, applied immediately and asynchronously. All outputs read 0 during reset, including o_CardOK and o_DeckRd.

## Timing
- The request is first sampled high in IDLE at cycle 0. o_DeckRd is high in cycle 1. Data is captured at the end of cycle 2. o_CardOK is high in cycle 3, and the updated o_HandP/o_HandD are already visible in that same cycle.
- Latency from request sample to o_CardOK is 3 cycles. The next request is sampled no earlier than cycle 4.
- The controller moves state on the edge after o_CardOK. Because ACK ignores requests, a still-high stale request is never double-served. A new-state request (for example, the dealer's first card immediately after the player's) is served starting in cycle 4.
- Back-to-back requests give a sustained throughput of one card per 4 cycles.
- o_CardOK, o_DeckRd, o_DeckAddr and all status outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.

## Configuration
- SOFT_ACE_EN defined: ace = 11 with the soft-demotion rule above; o_SoftP/o_SoftD are live.
- SOFT_ACE_EN undefined: ace = 1 always; soft counters and the demotion logic are removed; o_SoftP/o_SoftD are tied to 0.

## Test plan
- Player requests with deck [1,13]: after two requests, o_HandP=21, o_SoftP=1, and o_CardOK pulses exactly 3 cycles after each request sample.
- Player requests with deck [1,1,9,5]: the hand steps through 11(soft), 12(soft, 1 ace demoted), 21(soft), then 16 (o_SoftP=0).
- Both requests high in the same cycle with deck [7,4]: the player gets 7 first, and the dealer gets 4 only after its own request is sampled in IDLE. A held player request served across ACK yields exactly one card.
- i_Clear asserted in ADD, and separately i_Reset_n pulsed low in READ: no o_CardOK, hands = 0, o_DeckAddr = 0 on the next read.
- 53 sequential requests with DECK_SIZE=52: the 53rd read uses address 0, and o_DeckWrap goes to 1 on the 52nd ADD.
- SOFT_ACE_EN undefined with deck [1,13]: o_HandP=11 and o_SoftP=0. Deck [0] gives hand +0 and sets o_BadCard.
